// File: rtl/pipe_stall_ctrl.sv
// Hazard/stall controller for the 5-stage pipeline: memory wait FSM, branch flush, load-use stall, ID forwarding.
// Optional performance counters are enabled by defining PIPE_PERF_CNT_EN.
module pipe_stall_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 64,
    parameter int unsigned CNT_W       = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] rs,
    input  logic [4:0] rt,
    input  logic       use_rs,
    input  logic       use_rt,
    input  logic       ewreg,
    input  logic       em2reg,
    input  logic [4:0] ern,
    input  logic       mwreg,
    input  logic       mm2reg,
    input  logic       mwmem,
    input  logic [4:0] mrn,
    input  logic       ex_is_cond,
    input  logic       ex_taken,
    input  logic       dmem_ack,
    output logic       dmem_req,
    output logic       pc_we,
    output logic       ifid_we,
    output logic       ifid_flush,
    output logic       de_we,
    output logic       de_bubble,
    output logic       em_we,
    output logic       mw_bubble,
    output logic [1:0] fwda,
    output logic [1:0] fwdb,
    output logic       mem_fault
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] memwait_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, MEM_WAIT, FAULT} state_t;

    localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

    if (CNT_W < 1 || MEM_TIMEOUT < 2 || MEM_TIMEOUT > 255) begin : g_param_check
        $error("pipe_stall_ctrl: MEM_TIMEOUT must be 2..255 and CNT_W >= 1");
    end

    state_t     state;
    logic [7:0] wait_cnt;
    logic       mem_acc;
    logic       freeze;
    logic       branch;
    logic       load_use;

    function automatic logic [1:0] fwd_sel(input logic [4:0] r);
        if (ewreg && !em2reg && ern != 5'd0 && ern == r)
            return 2'd1;
        else if (mwreg && mm2reg && mrn != 5'd0 && mrn == r)
            return 2'd3;
        else if (mwreg && mrn != 5'd0 && mrn == r)
            return 2'd2;
        else
            return 2'd0;
    endfunction

    always_comb begin
        mem_acc  = mwmem | mm2reg;
        branch   = ex_is_cond & ex_taken;
        load_use = ewreg & em2reg & (ern != 5'd0) &
                   ((use_rs & (ern == rs)) | (use_rt & (ern == rt)));
        unique case (state)
            IDLE:     freeze = mem_acc & ~dmem_ack;
            MEM_WAIT: freeze = ~dmem_ack;
            FAULT:    freeze = 1'b1;
            default:  freeze = 1'b1;
        endcase

        dmem_req   = 1'b0;
        pc_we      = 1'b1;
        ifid_we    = 1'b1;
        ifid_flush = 1'b0;
        de_we      = 1'b1;
        de_bubble  = 1'b0;
        em_we      = 1'b1;
        mw_bubble  = 1'b0;
        fwda       = 2'd0;
        fwdb       = 2'd0;

        if (!rst) begin
            dmem_req = mem_acc & (state != FAULT);
            fwda     = fwd_sel(rs);
            fwdb     = fwd_sel(rt);
            // EX is held during a freeze, so flush/load-use wait until it releases.
            if (freeze) begin
                pc_we     = 1'b0;
                ifid_we   = 1'b0;
                de_we     = 1'b0;
                em_we     = 1'b0;
                mw_bubble = 1'b1;
            end else if (branch) begin
                ifid_flush = 1'b1;
                de_bubble  = 1'b1;
            end else if (load_use) begin
                pc_we     = 1'b0;
                ifid_we   = 1'b0;
                de_bubble = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            mem_fault <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (mem_acc && !dmem_ack) begin
                        state    <= MEM_WAIT;
                        wait_cnt <= 8'd1;
                    end
                end
                MEM_WAIT: begin
                    if (dmem_ack) begin
                        state    <= IDLE;
                        wait_cnt <= '0;
                    end else if (wait_cnt == TIMEOUT) begin
                        state     <= FAULT;
                        wait_cnt  <= '0;
                        mem_fault <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                FAULT: state <= FAULT;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef PIPE_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt   <= '0;
            flush_cnt   <= '0;
            memwait_cnt <= '0;
        end else begin
            if (!pc_we && stall_cnt != '1)
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (ifid_flush && flush_cnt != '1)
                flush_cnt <= flush_cnt + CNT_W'(1);
            if (state == MEM_WAIT && memwait_cnt != '1)
                memwait_cnt <= memwait_cnt + CNT_W'(1);
        end
    end
`endif

endmodule
